r4_div_iter: RTL and testbench

//  Iterative radix-4 SRT fraction-division core, one quotient digit {-2..+2} per cycle.

---
 rtl/r4_div_pkg.sv | 29 ++
 rtl/r4_div_iter_if.sv | 30 +++
 rtl/r4_qds.sv | 34 +++
 rtl/r4_div_iter.sv | 160 ++++++++++++++++
 tb/tb_r4_div_iter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/r4_div_pkg.sv
// Shared types and constants for the radix-4 SRT division core and its
// quotient-digit selection table.
package r4_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    POST,
    DONE
  } state_t;

  // Bit positions of the one-hot quotient digit returned by r4_qds.
  localparam int QDS_NEG2 = 4;
  localparam int QDS_NEG1 = 3;
  localparam int QDS_ZERO = 2;
  localparam int QDS_POS1 = 1;
  localparam int QDS_POS2 = 0;

  // Residual is two's complement with 3 integer bits; the estimate keeps 3 of each.
  localparam int RES_INT_BITS = 3;
  localparam int EST_W        = 6;

  // Selection thresholds in units of 1/8, valid for d in [63/64, 9/8].
  localparam logic signed [EST_W-1:0] QDS_M_POS2 = 6'sd12;   //  1.5
  localparam logic signed [EST_W-1:0] QDS_M_POS1 = 6'sd3;    //  0.375
  localparam logic signed [EST_W-1:0] QDS_M_ZERO = -6'sd4;   // -0.5
  localparam logic signed [EST_W-1:0] QDS_M_NEG1 = -6'sd13;  // -1.625

endpackage

// File: rtl/r4_div_iter_if.sv
// Start/finish handshake bundle between the fpdiv front-end, the iterative
// divider core and the rounding stage.
interface r4_div_iter_if
  import r4_div_pkg::*;
#(
  parameter int FRAC_W     = 54,
  parameter int QUO_DIGITS = 28
);

  logic                             flush_i;
  logic                             start_valid_i;
  logic                             start_ready_o;
  logic [FRAC_W+RES_INT_BITS-1:0]   dividend_i;
  logic [FRAC_W:0]                  divisor_i;
  logic                             finish_valid_o;
  logic                             finish_ready_i;
  logic [2*QUO_DIGITS-1:0]          quo_o;
  logic                             sticky_o;

  modport master (
    output flush_i, start_valid_i, dividend_i, divisor_i, finish_ready_i,
    input  start_ready_o, finish_valid_o, quo_o, sticky_o
  );

  modport slave (
    input  flush_i, start_valid_i, dividend_i, divisor_i, finish_ready_i,
    output start_ready_o, finish_valid_o, quo_o, sticky_o
  );

endinterface

// File: rtl/r4_qds.sv
// Radix-4 quotient-digit selection from a 6-bit residual estimate; the
// prescaled divisor range makes the thresholds divisor-independent.
module r4_qds
  import r4_div_pkg::*;
#(
  parameter int QDS_ARCH = 2
) (
  input  logic [EST_W-1:0] rem_i,
  output logic [4:0]       q_o
);

  logic signed [EST_W-1:0] est;
  assign est = signed'(rem_i);

  if (QDS_ARCH == 0) begin : g_chain
    always_comb begin
      // NOTE: assign every output a default first so no path through the block leaves it unassigned (no latch).
      q_o = '0;
      if (est >= QDS_M_POS2)      q_o[QDS_POS2] = 1'b1;
      else if (est >= QDS_M_POS1) q_o[QDS_POS1] = 1'b1;
      else if (est >= QDS_M_ZERO) q_o[QDS_ZERO] = 1'b1;
      else if (est >= QDS_M_NEG1) q_o[QDS_NEG1] = 1'b1;
      else                        q_o[QDS_NEG2] = 1'b1;
    end
  end else begin : g_range
    // Each digit decoded independently from its own interval.
    assign q_o[QDS_POS2] = (est >= QDS_M_POS2);
    assign q_o[QDS_POS1] = (est >= QDS_M_POS1) && (est < QDS_M_POS2);
    assign q_o[QDS_ZERO] = (est >= QDS_M_ZERO) && (est < QDS_M_POS1);
    assign q_o[QDS_NEG1] = (est >= QDS_M_NEG1) && (est < QDS_M_ZERO);
    assign q_o[QDS_NEG2] = (est < QDS_M_NEG1);
  end

endmodule

// File: rtl/r4_div_iter.sv
// Iterative radix-4 SRT fraction divider: carry-save residual, one digit per
// cycle, on-the-fly quotient conversion and a final sign/sticky correction.
module r4_div_iter
  import r4_div_pkg::*;
#(
  parameter int FRAC_W     = 54,
  parameter int QUO_DIGITS = 28,
  parameter int QDS_ARCH   = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  r4_div_iter_if.slave   bus
);

  localparam int W     = FRAC_W + RES_INT_BITS;
  localparam int QW    = 2 * QUO_DIGITS;
  localparam int CNT_W = (QUO_DIGITS > 1) ? $clog2(QUO_DIGITS) : 1;

  state_t           state, state_nxt;
  logic [W-1:0]     ws, wc;
  logic [FRAC_W:0]  d;
  logic [QW-1:0]    q_acc, qm_acc;
  logic [CNT_W-1:0] cnt;
  logic [QW-1:0]    quo;
  logic             sticky;
  logic             accept;

  assign bus.start_ready_o  = (state == IDLE) && !bus.flush_i;
  assign bus.finish_valid_o = (state == DONE);
  assign bus.quo_o          = quo;
  assign bus.sticky_o       = sticky;
  assign accept             = bus.start_valid_i && bus.start_ready_o;

  // Residual estimate: truncated tops of 4ws and 4wc, summed modulo 64.
  logic [W-1:0]     ws_x4, wc_x4;
  logic [EST_W-1:0] est;
  logic [4:0]       q_onehot;

  assign ws_x4 = {ws[W-3:0], 2'b00};
  assign wc_x4 = {wc[W-3:0], 2'b00};
  assign est   = ws_x4[W-1 -: EST_W] + wc_x4[W-1 -: EST_W];

  r4_qds #(.QDS_ARCH(QDS_ARCH)) u_qds (
    .rem_i (est),
    .q_o   (q_onehot)
  );

  // Divisor multiple and on-the-fly conversion, both keyed on the digit.
  logic [W-1:0]  d1, d2, dmul;
  logic          inj;
  logic [QW-1:0] q_nxt, qm_nxt;

  assign d1 = {{(W-FRAC_W-1){1'b0}}, d};
  assign d2 = {d1[W-2:0], 1'b0};

  always_comb begin
    dmul   = '0;
    inj    = 1'b0;
    q_nxt  = {q_acc[QW-3:0], 2'd0};
    qm_nxt = {qm_acc[QW-3:0], 2'd3};
    case (1'b1)
      q_onehot[QDS_POS2]: begin
        dmul   = ~d2;
        inj    = 1'b1;
        q_nxt  = {q_acc[QW-3:0], 2'd2};
        qm_nxt = {q_acc[QW-3:0], 2'd1};
      end
      q_onehot[QDS_POS1]: begin
        dmul   = ~d1;
        inj    = 1'b1;
        q_nxt  = {q_acc[QW-3:0], 2'd1};
        qm_nxt = {q_acc[QW-3:0], 2'd0};
      end
      q_onehot[QDS_ZERO]: ;
      q_onehot[QDS_NEG1]: begin
        dmul   = d1;
        q_nxt  = {qm_acc[QW-3:0], 2'd3};
        qm_nxt = {qm_acc[QW-3:0], 2'd2};
      end
      q_onehot[QDS_NEG2]: begin
        dmul   = d2;
        q_nxt  = {qm_acc[QW-3:0], 2'd2};
        qm_nxt = {qm_acc[QW-3:0], 2'd1};
      end
      default: ;
    endcase
  end

  // 3:2 compressor; the two's-complement +1 lands in the carry's empty LSB.
  logic [W-1:0] ws_nxt, wc_nxt;
  logic [W-2:0] maj;

  assign maj    = (ws_x4[W-2:0] & wc_x4[W-2:0]) |
                  (ws_x4[W-2:0] & dmul[W-2:0])  |
                  (wc_x4[W-2:0] & dmul[W-2:0]);
  assign ws_nxt = ws_x4 ^ wc_x4 ^ dmul;
  assign wc_nxt = {maj, inj};

  logic [W-1:0] w_final;
  assign w_final = ws + wc;

  always_comb begin
    state_nxt = state;
    if (bus.flush_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start_valid_i) state_nxt = ITER;
        ITER:    if (cnt == '0) state_nxt = POST;
        POST:    state_nxt = DONE;
        DONE:    if (bus.finish_ready_i) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws     <= '0;
      wc     <= '0;
      d      <= '0;
      q_acc  <= '0;
      qm_acc <= '0;
      cnt    <= '0;
      quo    <= '0;
      sticky <= 1'b0;
    end else if (!bus.flush_i) begin
      case (state)
        IDLE: if (accept) begin
          ws     <= bus.dividend_i;
          wc     <= '0;
          d      <= bus.divisor_i;
          q_acc  <= '0;
          qm_acc <= '0;
          cnt    <= CNT_W'(QUO_DIGITS - 1);
        end
        ITER: begin
          ws     <= ws_nxt;
          wc     <= wc_nxt;
          q_acc  <= q_nxt;
          qm_acc <= qm_nxt;
          cnt    <= cnt - CNT_W'(1);
        end
        POST: begin
          // A negative remainder means the last digit overshot by one ulp.
          quo    <= w_final[W-1] ? qm_acc : q_acc;
          sticky <= |w_final;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_r4_div_iter.sv
// Self-checking bench for r4_div_iter: directed cases, handshake/flush/reset
// scenarios and random operands against an exact long-division model.
module tb_r4_div_iter;

  localparam int FRAC_W     = 54;
  localparam int QUO_DIGITS = 28;
  localparam int XW         = FRAC_W + 3;
  localparam int DW         = FRAC_W + 1;
  localparam int QW         = 2 * QUO_DIGITS;
  localparam int LAT        = QUO_DIGITS + 2;
  localparam int N_RANDOM   = 1000;

  logic clk;
  logic rst_n;

  r4_div_iter_if #(.FRAC_W(FRAC_W), .QUO_DIGITS(QUO_DIGITS)) bus ();

  r4_div_iter #(.FRAC_W(FRAC_W), .QUO_DIGITS(QUO_DIGITS), .QDS_ARCH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Exact reference: floor(x * 4^N / d) and whether the division leaves a remainder.
  function automatic void ref_div(input logic [XW-1:0] x, input logic [DW-1:0] dv,
                                  output logic [QW-1:0] q, output logic s);
    logic [127:0] num, den;
    num = 128'(x) << QW;
    den = 128'(dv);
    q   = QW'(num / den);
    s   = (num % den) != 0;
  endfunction

  // Legal operands: d in [63/64, 9/8], 0 <= x <= (2/3)d.
  task automatic rand_operands(input bit x_max, output logic [XW-1:0] x, output logic [DW-1:0] dv);
    logic [127:0] r, dd, xm;
    r  = {64'd0, $urandom, $urandom};
    dd = (128'd63 << (FRAC_W - 6)) + r % ((128'd9 << (FRAC_W - 6)) + 128'd1);
    xm = (dd * 2) / 3;
    r  = {32'd0, $urandom, $urandom, $urandom};
    x  = XW'(x_max ? xm : r % (xm + 128'd1));
    dv = DW'(dd);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input string tag, input logic [XW-1:0] x, input logic [DW-1:0] dv);
    int guard;
    guard = 0;
    while (bus.start_ready_o !== 1'b1 && guard < 64) begin
      cycle();
      guard++;
    end
    check({tag, "/ready"}, 128'(bus.start_ready_o), 128'(1'b1));
    bus.start_valid_i = 1'b1;
    bus.dividend_i    = x;
    bus.divisor_i     = dv;
    cycle();
    bus.start_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = 1;
    while (bus.finish_valid_o !== 1'b1 && lat < 64) begin
      cycle();
      lat++;
    end
    check({tag, "/valid"}, 128'(bus.finish_valid_o), 128'(1'b1));
  endtask

  task automatic retire();
    bus.finish_ready_i = 1'b1;
    cycle();
    bus.finish_ready_i = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [XW-1:0] x, input logic [DW-1:0] dv);
    logic [QW-1:0] eq;
    logic          es;
    int            lat;
    ref_div(x, dv, eq, es);
    start_op(tag, x, dv);
    wait_done(tag, lat);
    check({tag, "/latency"}, 128'(lat), 128'(LAT));
    check({tag, "/quo"}, 128'(bus.quo_o), 128'(eq));
    check({tag, "/sticky"}, 128'(bus.sticky_o), 128'(es));
    retire();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [XW-1:0] x;
    logic [DW-1:0] dv;
    logic [QW-1:0] eq;
    logic          es;
    int            lat;
    logic          seen;

    rst_n              = 1'b0;
    bus.flush_i        = 1'b0;
    bus.start_valid_i  = 1'b0;
    bus.dividend_i     = '0;
    bus.divisor_i      = '0;
    bus.finish_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();

    check("reset/ready", 128'(bus.start_ready_o), 128'(1'b1));
    check("reset/valid", 128'(bus.finish_valid_o), 128'(1'b0));
    check("reset/quo", 128'(bus.quo_o), 128'(0));
    check("reset/sticky", 128'(bus.sticky_o), 128'(1'b0));

    // x = 0.5, d = 1.0: quotient is exactly 2^55.
    start_op("half", XW'(1) << (FRAC_W - 1), DW'(1) << FRAC_W);
    wait_done("half", lat);
    check("half/latency", 128'(lat), 128'(LAT));
    check("half/quo", 128'(bus.quo_o), 128'(1) << 55);
    check("half/sticky", 128'(bus.sticky_o), 128'(1'b0));
    retire();

    run_op("zero", '0, DW'(1) << FRAC_W);
    // x = 1/3 truncated to 54 fraction bits over d = 1: the division is exact.
    run_op("third", XW'((128'd1 << FRAC_W) / 3), DW'(1) << FRAC_W);
    run_op("half_17_16", XW'(1) << (FRAC_W - 1), DW'(17) << (FRAC_W - 4));

    // Divisor range corners with the largest and smallest legal dividends.
    dv = DW'(63) << (FRAC_W - 6);
    run_op("dmin_xmax", XW'((128'(dv) * 2) / 3), dv);
    dv = DW'(9) << (FRAC_W - 3);
    run_op("dmax_xmax", XW'((128'(dv) * 2) / 3), dv);
    run_op("dmax_ulp", XW'(1), dv);

    // Result held under back-pressure; a start during DONE is ignored.
    rand_operands(1'b0, x, dv);
    ref_div(x, dv, eq, es);
    start_op("hold", x, dv);
    wait_done("hold", lat);
    check("hold/latency", 128'(lat), 128'(LAT));
    bus.start_valid_i = 1'b1;
    bus.dividend_i    = '0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold%0d/valid", i), 128'(bus.finish_valid_o), 128'(1'b1));
      check($sformatf("hold%0d/quo", i), 128'(bus.quo_o), 128'(eq));
      check($sformatf("hold%0d/sticky", i), 128'(bus.sticky_o), 128'(es));
      cycle();
    end
    bus.start_valid_i = 1'b0;
    check("hold/quo_end", 128'(bus.quo_o), 128'(eq));
    retire();
    check("b2b/valid_low", 128'(bus.finish_valid_o), 128'(1'b0));
    check("b2b/ready", 128'(bus.start_ready_o), 128'(1'b1));
    rand_operands(1'b0, x, dv);
    run_op("b2b", x, dv);

    // Flush while cnt == 10 (18th ITER cycle).
    rand_operands(1'b0, x, dv);
    start_op("flush_iter", x, dv);
    repeat (17) cycle();
    bus.flush_i = 1'b1;
    #1;
    check("flush_iter/ready_low", 128'(bus.start_ready_o), 128'(1'b0));
    cycle();
    bus.flush_i = 1'b0;
    #1;
    check("flush_iter/valid", 128'(bus.finish_valid_o), 128'(1'b0));
    check("flush_iter/idle", 128'(bus.start_ready_o), 128'(1'b1));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen = seen | (bus.finish_valid_o === 1'b1);
      cycle();
    end
    check("flush_iter/no_result", 128'(seen), 128'(1'b0));
    rand_operands(1'b0, x, dv);
    run_op("after_flush", x, dv);

    // Flush beats a start in the same cycle.
    bus.flush_i       = 1'b1;
    bus.start_valid_i = 1'b1;
    bus.dividend_i    = XW'(1) << (FRAC_W - 1);
    bus.divisor_i     = DW'(1) << FRAC_W;
    #1;
    check("flush_idle/ready_low", 128'(bus.start_ready_o), 128'(1'b0));
    cycle();
    bus.flush_i       = 1'b0;
    bus.start_valid_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen = seen | (bus.finish_valid_o === 1'b1);
      cycle();
    end
    check("flush_idle/no_result", 128'(seen), 128'(1'b0));

    // Flush beats the finish handshake; the result registers keep their value.
    rand_operands(1'b1, x, dv);
    ref_div(x, dv, eq, es);
    start_op("flush_done", x, dv);
    wait_done("flush_done", lat);
    bus.flush_i        = 1'b1;
    bus.finish_ready_i = 1'b1;
    cycle();
    bus.flush_i        = 1'b0;
    bus.finish_ready_i = 1'b0;
    #1;
    check("flush_done/valid", 128'(bus.finish_valid_o), 128'(1'b0));
    check("flush_done/quo_kept", 128'(bus.quo_o), 128'(eq));
    check("flush_done/sticky_kept", 128'(bus.sticky_o), 128'(es));
    check("flush_done/idle", 128'(bus.start_ready_o), 128'(1'b1));

    // Reset while cnt == 5 (23rd ITER cycle).
    rand_operands(1'b1, x, dv);
    start_op("rst_mid", x, dv);
    repeat (22) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid/valid", 128'(bus.finish_valid_o), 128'(1'b0));
    check("rst_mid/quo", 128'(bus.quo_o), 128'(0));
    check("rst_mid/sticky", 128'(bus.sticky_o), 128'(1'b0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    check("rst_mid/ready", 128'(bus.start_ready_o), 128'(1'b1));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen = seen | (bus.finish_valid_o === 1'b1);
      cycle();
    end
    check("rst_mid/no_result", 128'(seen), 128'(1'b0));
    run_op("after_rst", XW'(1) << (FRAC_W - 1), DW'(17) << (FRAC_W - 4));

    for (int i = 0; i < N_RANDOM; i++) begin
      rand_operands(i % 37 == 0, x, dv);
      run_op($sformatf("rand%0d", i), x, dv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
